// File: rtl/pudding_dac_loader.sv
// pudding_dac_loader: takes a unary DAC code over a valid/ready handshake,
// expands it to an N_CELLS thermometer pattern, shifts that pattern into the
// PUDDING daisychain MSB-first (first bit ends in cell N_CELLS-1), then
// commits it with a single transfer strobe (dir_o=1, daisychain to state).
//
// Handshake: a code is taken on any rising edge where code_valid_i and
// code_ready_o are both high; code_ready_o is high only while the loader
// is idle, and code_i / code_valid_i are ignored at all other times.
//
// Optional build macro: PUDDING_LOADER_DWA_EN adds data-weighted averaging.
// The ON window then starts at a rotating pointer (exposed on dwa_ptr_o),
// which advances by the committed code on every transfer.
module pudding_dac_loader #(
  parameter int N_CELLS = 128,
  parameter int CODE_W  = 8,
  localparam int PTR_W  = $clog2(N_CELLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  output logic              code_ready_o,
  output logic              datum_o,
  output logic              shift_o,
  output logic              transfer_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CODE_W-1:0] loaded_code_o
`ifdef PUDDING_LOADER_DWA_EN
  ,
  output logic [PTR_W-1:0]  dwa_ptr_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   loaded_q, loaded_d;
  logic                datum_q, datum_d;
  logic                shift_q, shift_d;
  logic                transfer_q, transfer_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                dir_q;
  logic [PTR_W-1:0]    ptr_cur;
  logic [CODE_W-1:0]   code_clamped;

`ifdef PUDDING_LOADER_DWA_EN
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  assign ptr_cur   = ptr_q;
  assign dwa_ptr_o = ptr_q;
`else
  // Without rotation the ON window always starts at cell 0.
  assign ptr_cur = '0;
`endif

  // Cell k is ON when its distance above the pointer (mod N_CELLS) is below the code.
  function automatic logic cell_on(input logic [PTR_W-1:0]  k,
                                   input logic [PTR_W-1:0]  p,
                                   input logic [CODE_W-1:0] c);
    logic [PTR_W-1:0] rel;
    rel = k - p;
    return {1'b0, rel} < c;
  endfunction

  assign code_clamped = (code_i > CODE_W'(N_CELLS)) ? CODE_W'(N_CELLS) : code_i;

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    loaded_d   = loaded_q;
    datum_d    = 1'b0;
    shift_d    = 1'b0;
    transfer_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
`ifdef PUDDING_LOADER_DWA_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (code_valid_i && ready_q) begin
          state_d = SHIFT;
          code_d  = code_clamped;
          cnt_d   = PTR_W'(N_CELLS - 1);
          datum_d = cell_on(PTR_W'(N_CELLS - 1), ptr_cur, code_clamped);
          shift_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          // Bit 0 has just gone out; next cycle commits the chain.
          state_d    = XFER;
          transfer_d = 1'b1;
          loaded_d   = code_q;
`ifdef PUDDING_LOADER_DWA_EN
          // code mod N_CELLS is just its low PTR_W bits (code==N_CELLS wraps to 0).
          ptr_d      = ptr_q + code_q[PTR_W-1:0];
`endif
        end else begin
          cnt_d   = cnt_q - 1'b1;
          datum_d = cell_on(cnt_q - 1'b1, ptr_cur, code_q);
          shift_d = 1'b1;
        end
      end
      XFER: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      loaded_q   <= '0;
      datum_q    <= 1'b0;
      shift_q    <= 1'b0;
      transfer_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      dir_q      <= 1'b1;
`ifdef PUDDING_LOADER_DWA_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      loaded_q   <= loaded_d;
      datum_q    <= datum_d;
      shift_q    <= shift_d;
      transfer_q <= transfer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      dir_q      <= 1'b1;
`ifdef PUDDING_LOADER_DWA_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign code_ready_o  = ready_q;
  assign datum_o       = datum_q;
  assign shift_o       = shift_q;
  assign transfer_o    = transfer_q;
  assign dir_o         = dir_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign loaded_code_o = loaded_q;

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Bench for pudding_dac_loader: table-driven and random loads scored against
// a thermometer/rotation model of the downstream daisychain + state register.
// Build with PUDDING_LOADER_DWA_EN defined to cover the rotation feature.
module tb_pudding_dac_loader;

  localparam int N = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code_i;
  logic       code_valid_i;
  logic       code_ready_o, datum_o, shift_o, transfer_o, dir_o, busy_o, done_o;
  logic [7:0] loaded_code_o;
`ifdef PUDDING_LOADER_DWA_EN
  logic [6:0] dwa_ptr_o;
`endif

  pudding_dac_loader #(.N_CELLS(N), .CODE_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_i        (code_i),
    .code_valid_i  (code_valid_i),
    .code_ready_o  (code_ready_o),
    .datum_o       (datum_o),
    .shift_o       (shift_o),
    .transfer_o    (transfer_o),
    .dir_o         (dir_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .loaded_code_o (loaded_code_o)
`ifdef PUDDING_LOADER_DWA_EN
    ,
    .dwa_ptr_o     (dwa_ptr_o)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp(input int c);
    return (c > N) ? N : c;
  endfunction

  // Thermometer of c ones starting at cell 0, rotated up by p cells.
  function automatic logic [127:0] model(input int c, input int p);
    logic [127:0] t;
    logic [127:0] r;
    t = (c >= N) ? '1 : ((128'd1 << c) - 128'd1);
    r = (p == 0) ? t : ((t << p) | (t >> (N - p)));
    return r;
  endfunction

  // ---------------- scoreboard / downstream model ----------------
  logic [127:0] exp_q[$];
  int           hs_q[$];
  int           ld_q[$];
  int           hs_log[$];
  logic [127:0] chain = '0;
  logic [127:0] state_reg = '0;
  int shift_idx = 0, datum_err = 0, overlap_cnt = 0, busy_err = 0;
  int xfer_cnt = 0, done_cnt = 0, last_hs = 0, ptr_m = 0;

  // Daisychain and state-register model plus per-load checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chain = '0;
      state_reg = '0;
      exp_q.delete();
      hs_q.delete();
      ld_q.delete();
      shift_idx = 0;
      datum_err = 0;
      ptr_m = 0;
    end else begin
      if (shift_o && transfer_o) overlap_cnt++;
      if (shift_o) begin
        if (!busy_o) busy_err++;
        if (exp_q.size() > 0 && shift_idx < N)
          if (datum_o !== exp_q[0][N - 1 - shift_idx]) datum_err++;
        chain = {chain[126:0], datum_o};
        shift_idx++;
      end
      if (transfer_o) begin
        if (!busy_o) busy_err++;
        check("shift_count", 128'(shift_idx), 128'(N));
        check("datum_bits", 128'(datum_err), 128'd0);
        check("dir", 128'(dir_o), 128'd1);
        if (exp_q.size() > 0) begin
          check("state", chain, exp_q[0]);
          check("loaded_code", 128'(loaded_code_o), 128'(ld_q[0]));
          check("xfer_latency", 128'(cyc - hs_q[0]), 128'(N + 1));
          last_hs = hs_q[0];
          void'(exp_q.pop_front());
          void'(hs_q.pop_front());
          void'(ld_q.pop_front());
        end else begin
          check("xfer_pending", 128'(exp_q.size()), 128'd1);
        end
        state_reg = chain;
        shift_idx = 0;
        datum_err = 0;
        xfer_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        check("done_latency", 128'(cyc - last_hs), 128'(N + 2));
        check("done_ready", 128'({code_ready_o, busy_o}), 128'b10);
`ifdef PUDDING_LOADER_DWA_EN
        check("dwa_ptr", 128'(dwa_ptr_o), 128'(ptr_m));
`endif
      end
      if (code_valid_i && code_ready_o) begin
        hs_log.push_back(cyc);
        hs_q.push_back(cyc);
        ld_q.push_back(clamp(int'(code_i)));
`ifdef PUDDING_LOADER_DWA_EN
        exp_q.push_back(model(clamp(int'(code_i)), ptr_m));
        ptr_m = (ptr_m + clamp(int'(code_i))) % N;
`else
        exp_q.push_back(model(clamp(int'(code_i)), 0));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    code_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int c, output int t_hs);
    @(posedge clk); #1;
    code_i = 8'(c);
    code_valid_i = 1'b1;
    t_hs = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (code_ready_o) begin
        t_hs = cyc;
        break;
      end
    end
    if (t_hs < 0) fail_now("handshake_timeout");
    @(posedge clk); #1;
    code_valid_i = 1'b0;
    code_i = 8'($urandom);   // must not affect the load in progress
  endtask

  task automatic wait_done();
    int  d0 = done_cnt;
    bit  ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int code;
    int exp_loaded;
    int exp_ones;
  } vec_t;
  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int t, xf0, dn0;
    logic [127:0] e;

    vecs[0] = '{code: 0,   exp_loaded: 0,   exp_ones: 0};
    vecs[1] = '{code: 128, exp_loaded: 128, exp_ones: 128};
    vecs[2] = '{code: 200, exp_loaded: 128, exp_ones: 128};
    vecs[3] = '{code: 1,   exp_loaded: 1,   exp_ones: 1};
    vecs[4] = '{code: 127, exp_loaded: 127, exp_ones: 127};
    vecs[5] = '{code: 255, exp_loaded: 128, exp_ones: 128};

    rst_n = 1'b0;
    code_i = 8'd0;
    code_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(code_ready_o), 128'd0);
    check("rst_strobes", 128'({datum_o, shift_o, transfer_o, busy_o, done_o}), 128'd0);
    check("rst_dir", 128'(dir_o), 128'd1);
    check("rst_loaded", 128'(loaded_code_o), 128'd0);
`ifdef PUDDING_LOADER_DWA_EN
    check("rst_ptr", 128'(dwa_ptr_o), 128'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 128'(code_ready_o), 128'd1);

    // Code 5 right after reset: 5 ON cells at the bottom.
    do_load(5, t);
    wait_done();
    check("code5_state", state_reg, 128'h1F);
    check("code5_loaded", 128'(loaded_code_o), 128'd5);

    // Table-driven boundary codes.
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].code, t);
      wait_done();
      check("vec_loaded", 128'(loaded_code_o), 128'(vecs[i].exp_loaded));
      check("vec_ones", 128'($countones(state_reg)), 128'(vecs[i].exp_ones));
    end

    // Random codes with random idle gaps.
    for (int i = 0; i < 8; i++) begin
      int c;
      c = $urandom_range(0, 255);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_load(c, t);
      wait_done();
      check("rnd_loaded", 128'(loaded_code_o), 128'(clamp(c)));
      check("rnd_ones", 128'($countones(state_reg)), 128'(clamp(c)));
    end

    // Back-to-back: valid held, second code accepted in the done cycle.
    do_reset();
    code_i = 8'd3;
    code_valid_i = 1'b1;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (code_ready_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) fail_now("b2b_handshake");
    @(posedge clk); #1 code_i = 8'd64;
    wait_done();
    #1 code_valid_i = 1'b0;
    wait_done();
    if (hs_log.size() >= 2)
      check("b2b_gap", 128'(hs_log[hs_log.size() - 1] - hs_log[hs_log.size() - 2]), 128'(N + 2));
    else
      fail_now("b2b_second_handshake");
`ifdef PUDDING_LOADER_DWA_EN
    e = ((128'd1 << 64) - 128'd1) << 3;
`else
    e = (128'd1 << 64) - 128'd1;
`endif
    check("b2b_state", state_reg, e);
    check("b2b_loaded", 128'(loaded_code_o), 128'd64);

    // Reset during SHIFT cycle 40 of a code=100 load.
    do_load(100, t);
    do begin
      @(posedge clk); #1;
    end while (cyc < t + 40);
    rst_n = 1'b0;
    xf0 = xfer_cnt;
    dn0 = done_cnt;
    @(negedge clk);
    check("midrst_shifting", 128'(shift_o), 128'd1);
    @(negedge clk);
    check("midrst_strobes", 128'({datum_o, shift_o, transfer_o, busy_o, done_o, code_ready_o}), 128'd0);
    check("midrst_loaded", 128'(loaded_code_o), 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 128'(code_ready_o), 128'd1);
    repeat (150) @(posedge clk);
    check("midrst_no_xfer", 128'(xfer_cnt), 128'(xf0));
    check("midrst_no_done", 128'(done_cnt), 128'(dn0));

`ifdef PUDDING_LOADER_DWA_EN
    // Rotation: 100 then 50 from pointer 0.
    do_reset();
    do_load(100, t);
    wait_done();
    check("dwa_first", state_reg, (128'd1 << 100) - 128'd1);
    do_load(50, t);
    wait_done();
    e = '1;
    e = (e << 100) | ((128'd1 << 22) - 128'd1);
    check("dwa_second", state_reg, e);
    check("dwa_ptr_final", 128'(dwa_ptr_o), 128'd22);
`endif

    repeat (5) @(posedge clk);
    check("no_overlap", 128'(overlap_cnt), 128'd0);
    check("busy_during_load", 128'(busy_err), 128'd0);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
